// File: rtl/afifo_clear_ctrl.sv
// Purpose: sequences a four-phase clear req/ack handshake across NUM_CH FIFO clock domains with timeout supervision.
// Latency: req rises 2 cycles after clear_start rises; each ack edge costs SYNC_STAGES cycles plus 1 to react.
// Backpressure: start edges outside IDLE are dropped, not queued; a stalled channel aborts after TIMEOUT_CYCLES.
module afifo_clear_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              main_clk,
    input  logic              main_rst,
    input  logic              clear_start,
    input  logic [NUM_CH-1:0] clear_mask,
    output logic [NUM_CH-1:0] ch_clear_req,
    input  logic [NUM_CH-1:0] ch_clear_ack,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              clear_timeout,
    output logic [NUM_CH-1:0] clear_err_ch
);

    // A zero timeout disables supervision; keep the counter at least one bit wide.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int               CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] ack_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] ack_s;
    logic              start_q, start_d, start_edge;
    logic [NUM_CH-1:0] mask_r, mask_nxt;
    logic [NUM_CH-1:0] err_nxt;
    logic [CNT_W-1:0]  to_cnt;
    logic              all_acked, all_released, to_hit;

    // Bring every channel's ack into main_clk through its own flop chain.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) ack_sync[i] <= '0;
        end else begin
            ack_sync[0] <= ch_clear_ack;
            for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Register the start request and keep one older copy for rising-edge detection.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            start_q <= 1'b0;
            start_d <= 1'b0;
        end else begin
            start_q <= clear_start;
            start_d <= start_q;
        end
    end

    assign start_edge   = start_q & ~start_d;
    // Unmasked channels drop out of both completion tests.
    assign all_acked    = ((ack_s & mask_r) == mask_r);
    assign all_released = ((ack_s & mask_r) == '0);
    assign to_hit       = TO_EN && (to_cnt == TO_LAST);

    // Next-state logic; exit conditions take priority over a coinciding timeout.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_r;
        err_nxt   = clear_err_ch;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    mask_nxt  = clear_mask;
                    err_nxt   = '0;
                    state_nxt = (clear_mask != '0) ? ST_ASSERT : ST_DONE;
                end
            end
            ST_ASSERT: begin
                if (all_acked) begin
                    state_nxt = ST_RELEASE;
                end else if (to_hit) begin
                    state_nxt = ST_ABORT;
                    err_nxt   = mask_r & ~ack_s;
                end
            end
            ST_RELEASE: begin
                if (all_released) begin
                    state_nxt = ST_DONE;
                end else if (to_hit) begin
                    state_nxt = ST_ABORT;
                    err_nxt   = mask_r & ack_s;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, latched mask and every output are registered from the next state so nothing is combinational to a pin.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state         <= ST_IDLE;
            mask_r        <= '0;
            ch_clear_req  <= '0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            clear_timeout <= 1'b0;
            clear_err_ch  <= '0;
        end else begin
            state         <= state_nxt;
            mask_r        <= mask_nxt;
            ch_clear_req  <= (state_nxt == ST_ASSERT) ? mask_nxt : '0;
            clear_busy    <= (state_nxt == ST_ASSERT) || (state_nxt == ST_RELEASE);
            clear_done    <= (state_nxt == ST_DONE);
            clear_timeout <= (state_nxt == ST_ABORT);
            clear_err_ch  <= err_nxt;
        end
    end

    // Per-phase cycle counter: zeroed on any state change, counts while a handshake phase is open.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            to_cnt <= '0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if (TO_EN && ((state == ST_ASSERT) || (state == ST_RELEASE))) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_afifo_clear_ctrl.sv
// Purpose: scoreboard bench for afifo_clear_ctrl with behavioural per-channel responders.
// Latency: expected outcomes are predicted per sequence and matched when done/timeout pulses appear.
// Backpressure: every wait is bounded; an expired bound is reported and the run continues to the summary.
module tb_afifo_clear_ctrl;

    localparam int NCH = 2;
    localparam int TO  = 16;

    logic           main_clk = 1'b0;
    logic           main_rst = 1'b1;
    logic           clear_start = 1'b0;
    logic [NCH-1:0] clear_mask = '0;
    logic [NCH-1:0] ch_clear_ack = '0;
    logic [NCH-1:0] ch_clear_req;
    logic           clear_busy, clear_done, clear_timeout;
    logic [NCH-1:0] clear_err_ch;

    afifo_clear_ctrl #(.NUM_CH(NCH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .main_clk      (main_clk),
        .main_rst      (main_rst),
        .clear_start   (clear_start),
        .clear_mask    (clear_mask),
        .ch_clear_req  (ch_clear_req),
        .ch_clear_ack  (ch_clear_ack),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .clear_timeout (clear_timeout),
        .clear_err_ch  (clear_err_ch)
    );

    always #5 main_clk = ~main_clk;

    int cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    typedef struct {
        bit             is_to;
        logic [NCH-1:0] err;
        int             rises;
        int             start_cyc;
        bit             chk_lat;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             errors = 0;
    logic [NCH-1:0] cur_mask = '0;
    logic [NCH-1:0] last_err = '0;
    // Responder behaviour per channel: 0 = normal, 1 = never acks, 2 = ack stuck high.
    int             mode[NCH];
    int             dly[NCH];
    int             rcnt[NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Target-domain responders: a normal channel mirrors its req after dly cycles.
    initial begin
        for (int c = 0; c < NCH; c++) begin
            mode[c] = 0;
            dly[c]  = 1;
            rcnt[c] = 0;
        end
        forever begin
            @(posedge main_clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                case (mode[c])
                    1: ch_clear_ack[c] = 1'b0;
                    2: ch_clear_ack[c] = 1'b1;
                    default: begin
                        if (ch_clear_req[c] !== ch_clear_ack[c]) begin
                            rcnt[c]++;
                            if (rcnt[c] >= dly[c]) begin
                                ch_clear_ack[c] = ch_clear_req[c];
                                rcnt[c] = 0;
                            end
                        end else begin
                            rcnt[c] = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: tracks req activity and checks each done/timeout pulse against the scoreboard.
    initial begin : monitor
        bit   prev_nz;
        int   rises;
        int   rise_cyc;
        exp_t e;
        prev_nz  = 1'b0;
        rises    = 0;
        rise_cyc = 0;
        forever begin
            @(negedge main_clk);
            if (main_rst) begin
                prev_nz = 1'b0;
                rises   = 0;
            end else begin
                if (ch_clear_req != '0 && !prev_nz) begin
                    rises++;
                    rise_cyc = cyc;
                    chk("req_eq_mask", 32'(ch_clear_req), 32'(cur_mask));
                end
                prev_nz = (ch_clear_req != '0);
                if (clear_done || clear_timeout) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got done=%0d timeout=%0d expected none (cycle %0d)",
                                 clear_done, clear_timeout, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_kind", {clear_timeout, clear_done}, e.is_to ? 2'b10 : 2'b01);
                        chk("err_ch", 32'(clear_err_ch), 32'(e.err));
                        chk("req_rises", rises, e.rises);
                        chk("req_at_pulse", 32'(ch_clear_req), 0);
                        chk("busy_at_pulse", 32'(clear_busy), 0);
                        if (e.rises == 1) chk("req_rise_lat", rise_cyc - e.start_cyc, 2);
                        if (e.chk_lat) chk("pulse_lat", cyc - e.start_cyc, e.lat);
                    end
                    rises = 0;
                end
            end
        end
    end

    // Reference model: outcome of one sequence from the mask and each channel's responder behaviour.
    function automatic exp_t predict(input logic [NCH-1:0] mask, input int sc);
        exp_t           e;
        logic [NCH-1:0] never, stuck;
        for (int c = 0; c < NCH; c++) begin
            never[c] = mask[c] && (mode[c] == 1);
            stuck[c] = mask[c] && (mode[c] == 2);
        end
        e.start_cyc = sc;
        e.chk_lat   = 1'b0;
        e.lat       = 0;
        e.rises     = (mask != '0) ? 1 : 0;
        e.is_to     = 1'b0;
        e.err       = '0;
        if (mask == '0) begin
            e.chk_lat = 1'b1;
            e.lat     = 2;
        end else if (never != '0) begin
            // Request phase gives up after TO cycles; pulse lands two edges later.
            e.is_to   = 1'b1;
            e.err     = never;
            e.chk_lat = 1'b1;
            e.lat     = TO + 2;
        end else if (stuck != '0) begin
            e.is_to = 1'b1;
            e.err   = stuck;
        end
        return e;
    endfunction

    task automatic wait_idle(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge main_clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge main_clk);
        #1;
    endtask

    task automatic setup(input int m0, input int m1, input int d0, input int d1);
        mode[0] = m0;
        mode[1] = m1;
        dly[0]  = d0;
        dly[1]  = d1;
        repeat (12) @(posedge main_clk);
        #1;
    endtask

    task automatic run_seq(input logic [NCH-1:0] mask, input int m0, input int m1,
                           input int d0, input int d1, input int hold);
        exp_t e;
        setup(m0, m1, d0, d1);
        chk("err_hold", 32'(clear_err_ch), 32'(last_err));
        e = predict(mask, cyc);
        sb.push_back(e);
        clear_mask  = mask;
        cur_mask    = mask;
        clear_start = 1'b1;
        repeat (hold) @(posedge main_clk);
        #1;
        clear_start = 1'b0;
        wait_idle(300);
        last_err = e.is_to ? e.err : '0;
    endtask

    initial begin : stim
        exp_t e;
        #1;
        repeat (3) @(posedge main_clk);
        #1;
        chk("rst_req", 32'(ch_clear_req), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_timeout", 32'(clear_timeout), 0);
        chk("rst_err", 32'(clear_err_ch), 0);
        main_rst = 1'b0;

        // Directed cases.
        run_seq(2'b11, 0, 0, 3, 3, 1);
        run_seq(2'b01, 0, 1, 3, 3, 2);
        run_seq(2'b11, 0, 1, 3, 3, 1);
        run_seq(2'b11, 2, 0, 2, 2, 1);
        run_seq(2'b00, 0, 0, 1, 1, 3);

        // Extra edge during the request phase and start held through completion.
        setup(0, 0, 3, 3);
        e = predict(2'b11, cyc);
        sb.push_back(e);
        clear_mask  = 2'b11;
        cur_mask    = 2'b11;
        clear_start = 1'b1;
        repeat (4) @(posedge main_clk);
        #1;
        clear_start = 1'b0;
        @(posedge main_clk);
        #1;
        clear_start = 1'b1;
        wait_idle(300);
        repeat (5) @(posedge main_clk);
        #1;
        clear_start = 1'b0;
        last_err = '0;
        run_seq(2'b11, 0, 0, 2, 4, 1);

        // Reset in the middle of the request phase.
        setup(0, 0, 4, 4);
        e = predict(2'b11, cyc);
        sb.push_back(e);
        clear_mask  = 2'b11;
        cur_mask    = 2'b11;
        clear_start = 1'b1;
        repeat (4) @(posedge main_clk);
        #1;
        chk("pre_rst_req", 32'(ch_clear_req), 32'(2'b11));
        chk("pre_rst_busy", 32'(clear_busy), 1);
        #2;
        main_rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(ch_clear_req), 0);
        chk("mid_rst_busy", 32'(clear_busy), 0);
        chk("mid_rst_pulses", {clear_done, clear_timeout}, 0);
        sb.delete();
        clear_start = 1'b0;
        repeat (3) @(posedge main_clk);
        #1;
        main_rst = 1'b0;
        last_err = '0;
        run_seq(2'b00, 0, 0, 1, 1, 1);
        run_seq(2'b11, 0, 0, 3, 3, 1);

        // Randomized sequences.
        for (int it = 0; it < 40; it++) begin
            int m[NCH];
            for (int c = 0; c < NCH; c++) begin
                int r = $urandom_range(0, 9);
                m[c] = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            end
            run_seq(2'($urandom_range(0, 3)), m[0], m[1], $urandom_range(1, 4),
                    $urandom_range(1, 4), $urandom_range(1, 3));
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/afifo_clear_ctrl.md
# afifo_clear_ctrl

Multi-channel clear sequencer for the AFIFO wrapper, running entirely in the main control clock domain. It runs a full four-phase req/ack handshake with every selected channel, one channel per FIFO clock domain. The block synchronises the returning acks, reports busy/done, and aborts on timeout with a per-channel error map. It generalises the two-domain clear synchronisation to NUM_CH channels with masking, release-phase tracking and timeout supervision.

## Interface
Parameters:
- NUM_CH, 2, number of clear channels (≥1)
- SYNC_STAGES, 2, synchroniser depth on each ch_clear_ack input (≥2)
- TIMEOUT_CYCLES, 256, max cycles per handshake phase; 0 disables timeout

Ports (one clock; reset is asynchronous and active-high):
- main_clk  in  1  control clock
- main_rst  in  1  asynchronous, active-high reset
- clear_start  in  1  clear request; rising edge triggers a sequence
- clear_mask  in  NUM_CH  channels to clear, sampled on accepted start
- ch_clear_req  out  NUM_CH  per-channel clear level, registered, to the target domains
- ch_clear_ack  in  NUM_CH  per-channel ack, asynchronous to main_clk
- clear_busy  out  1  sequence in progress
- clear_done  out  1  one-cycle pulse on successful completion
- clear_timeout  out  1  one-cycle pulse on abort
- clear_err_ch  out  NUM_CH  channels that failed the last aborted sequence

## Operation
- Each ch_clear_ack bit passes through a SYNC_STAGES-flop synchroniser to give ack_s. All flops reset to 0.
- clear_start is registered, and a rising edge is detected (start_q & ~start_d).
- FSM states: IDLE, ASSERT, RELEASE, DONE, ABORT.
- IDLE:
  - A start edge latches clear_mask into mask_r and clears clear_err_ch.
  - If mask_r is nonzero, go to ASSERT. If mask_r is zero, go to DONE.
  - Start edges in any other state are ignored and not queued.
- ASSERT:
  - ch_clear_req = mask_r and busy = 1.
  - When (ack_s & mask_r) == mask_r, go to RELEASE.
- RELEASE:
  - ch_clear_req = 0 and busy = 1.
  - When (ack_s & mask_r) == 0, go to DONE.
- DONE: clear_done = 1 for one cycle, then go to IDLE.
- ABORT:
  - ch_clear_req = 0 and clear_timeout = 1 for one cycle, then go to IDLE.
  - clear_err_ch is set to mask_r & ~ack_s if the timeout hit in ASSERT, or to mask_r & ack_s if it hit in RELEASE.
  - clear_err_ch holds until the next accepted start.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1). It is zeroed on entry to ASSERT and to RELEASE, and increments every cycle in those states.
  - When the counter equals TIMEOUT_CYCLES-1 and the exit condition is false, go to ABORT.
  - If the exit condition and the timeout coincide, the exit condition wins.
- Unmasked channels are never requested, and their acks are ignored.
- A held-high clear_start does not retrigger. It must drop and rise again.

## Timing
- Reset values: ch_clear_req = 0, clear_busy = 0, clear_done = 0, clear_timeout = 0, clear_err_ch = 0. State resets to IDLE, all sync and edge flops to 0.
- Reset mid-sequence drops ch_clear_req immediately (asynchronously) and does not pulse done.
- Start edge: clear_start rises before edge E0, so start_q = 1 after E0. At E1 the FSM leaves IDLE, and ch_clear_req/clear_busy are high after E1.
- Ack response: an ack rising before edge Ea is visible on ack_s SYNC_STAGES edges later. ch_clear_req falls one edge after that.
- Release mirrors the ack response. clear_done is high for the single cycle after RELEASE exits. clear_busy is low during DONE.
- Zero mask: clear_done pulses in the cycle after the IDLE→DONE edge, with no req activity.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Test plan
- NUM_CH=2, mask=2'b11, responder acks each req 3 cycles after seeing it and drops ack 3 cycles after req falls -> req 2'b11 asserted and removed once, one clear_done pulse, busy low afterward, err_ch=0.
- mask=2'b01, channel 1 never acks, channel 0 normal -> ch_clear_req[1] stays 0, completes with clear_done, no timeout.
- TIMEOUT_CYCLES=16, mask=2'b11, channel 1 never acks -> ABORT after 16 ASSERT cycles, clear_timeout pulse, err_ch=2'b10, req=0, no clear_done.
- TIMEOUT_CYCLES=16, channel 0 holds ack high forever -> RELEASE times out, err_ch=2'b01, clear_timeout pulse.
- Second start edge during ASSERT, plus clear_start held high through DONE -> exactly one sequence and one done pulse; a new edge after deassertion starts a second sequence.
- main_rst asserted mid-ASSERT -> req, busy and all pulses 0 in the same cycle. After release, a fresh start completes normally. mask=0 start gives done with no req.
